// File: rtl/n101_mrom_icb_ctrl_pkg.sv
// n101_mrom_icb_ctrl_pkg: shared sizing helpers for the mask-ROM ICB controller.
package n101_mrom_icb_ctrl_pkg;

  // Byte-offset bits inside one ROM word (log2 of bytes per word); DW is 32 or 64.
  function automatic int n101_mrom_bw(input int dw);
    return (dw == 64) ? 3 : 2;
  endfunction

  // Response FIFO pointer width, never narrower than one bit.
  function automatic int n101_mrom_ptr_w(input int outs);
    return (outs <= 1) ? 1 : $clog2(outs);
  endfunction

  // One FIFO entry carries the error flag on top of the data word.
  function automatic int n101_mrom_entry_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/n101_mrom.sv
// n101_mrom: combinational mask-ROM word array. Word 2 holds 0xDEADBEEF, every
// other word inside the depth holds 0xA5000000 ^ (index * 0x00010003), and
// indices at or beyond the depth read as zero.
module n101_mrom #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int DP = 1024
) (
  input  logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_dout
);

  function automatic logic [31:0] word32(input logic [AW-1:0] idx);
    logic [31:0] x;
    x = 32'(idx);
    if (x >= 32'(DP)) return 32'h0;
    if (x == 32'd2) return 32'hDEAD_BEEF;
    return 32'hA500_0000 ^ (x * 32'h0001_0003);
  endfunction

  // Pure table lookup, widened to 64 bits by pairing the word with its inverse.
  generate
    if (DW == 64) begin : g_dw64
      always_comb rom_dout = {~word32(rom_addr), word32(rom_addr)};
    end else begin : g_dw32
      always_comb rom_dout = word32(rom_addr);
    end
  endgenerate

endmodule

// File: rtl/n101_mrom_rsp_fifo.sv
// n101_mrom_rsp_fifo: small synchronous FIFO holding ROM responses in order.
// The head word is driven straight from the storage registers and reads as
// zero while the FIFO is empty.
module n101_mrom_rsp_fifo
  import n101_mrom_icb_ctrl_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head_data
);

  localparam int PW = n101_mrom_ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Entry storage; contents need no reset because the empty gate hides them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves cnt unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/n101_mrom_icb_ctrl.sv
// n101_mrom_icb_ctrl: registered ICB slave in front of the mask ROM with up to
// OUTS outstanding responses and write / misalignment / range error checks.
// Optional first-error address capture is built when N101_MROM_ERR_CAPTURE_EN
// is defined.
module n101_mrom_icb_ctrl
  import n101_mrom_icb_ctrl_pkg::*;
#(
  parameter int AW   = 12,
  parameter int DW   = 32,
  parameter int DP   = 1024,
  parameter int OUTS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rom_icb_cmd_valid,
  output logic          rom_icb_cmd_ready,
  input  logic [AW-1:0] rom_icb_cmd_addr,
  input  logic          rom_icb_cmd_read,
  output logic          rom_icb_rsp_valid,
  input  logic          rom_icb_rsp_ready,
  output logic          rom_icb_rsp_err,
  output logic [DW-1:0] rom_icb_rsp_rdata,
`ifdef N101_MROM_ERR_CAPTURE_EN
  output logic          rom_err_vld,
  output logic [AW-1:0] rom_err_addr,
  input  logic          rom_err_clr,
`endif
  output logic          rom_idle
);

  localparam int N101_MROM_BW = n101_mrom_bw(DW);
  localparam int IW           = AW - N101_MROM_BW;
  localparam int EW           = n101_mrom_entry_w(DW);
  localparam int CW           = $clog2(OUTS + 1);
  localparam logic [IW:0] DP_L = DP[IW:0];

  logic [IW-1:0] word_idx;
  logic [DW-1:0] rom_dout;
  logic          err_misalign;
  logic          err_range;
  logic          cmd_err;
  logic          accept;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head_data;

  assign word_idx     = rom_icb_cmd_addr[AW-1:N101_MROM_BW];
  assign err_misalign = (rom_icb_cmd_addr[N101_MROM_BW-1:0] != '0);
  assign err_range    = ({1'b0, word_idx} >= DP_L);
  assign cmd_err      = ~rom_icb_cmd_read | err_misalign | err_range;

  // No bypass: a full FIFO refuses commands even in a cycle that pops.
  assign rom_icb_cmd_ready = ~fifo_full;
  assign accept            = rom_icb_cmd_valid & rom_icb_cmd_ready;
  assign pop               = rom_icb_rsp_valid & rom_icb_rsp_ready;

  // Erroring commands never see array data; their entry is {err=1, data=0}.
  assign push_data = cmd_err ? {1'b1, {DW{1'b0}}} : {1'b0, rom_dout};

  n101_mrom #(
    .AW (IW),
    .DW (DW),
    .DP (DP)
  ) u_rom (
    .rom_addr (word_idx),
    .rom_dout (rom_dout)
  );

  n101_mrom_rsp_fifo #(
    .WIDTH (EW),
    .DEPTH (OUTS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (head_data)
  );

  assign rom_icb_rsp_valid = ~fifo_empty;
  assign rom_icb_rsp_err   = head_data[EW-1];
  assign rom_icb_rsp_rdata = head_data[DW-1:0];
  assign rom_idle          = (fifo_count == '0);

`ifdef N101_MROM_ERR_CAPTURE_EN
  // Sticky first-error capture; a clear in the same cycle as a new error wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_err_vld  <= 1'b0;
      rom_err_addr <= '0;
    end else if (rom_err_clr) begin
      rom_err_vld  <= 1'b0;
    end else if (accept && cmd_err && !rom_err_vld) begin
      rom_err_vld  <= 1'b1;
      rom_err_addr <= rom_icb_cmd_addr;
    end
  end
`endif

endmodule

// File: tb/tb_n101_mrom_icb_ctrl.sv
// Directed bench for n101_mrom_icb_ctrl (AW=13, DW=32, DP=1024, OUTS=2).
// Capture checks are compiled in when N101_MROM_ERR_CAPTURE_EN is defined.
module tb_n101_mrom_icb_ctrl;

  localparam int AW   = 13;
  localparam int DW   = 32;
  localparam int DP   = 1024;
  localparam int OUTS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_read;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          idle;
`ifdef N101_MROM_ERR_CAPTURE_EN
  logic          err_vld;
  logic [AW-1:0] err_addr;
  logic          err_clr;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  n101_mrom_icb_ctrl #(
    .AW (AW), .DW (DW), .DP (DP), .OUTS (OUTS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rom_icb_cmd_valid (cmd_valid),
    .rom_icb_cmd_ready (cmd_ready),
    .rom_icb_cmd_addr  (cmd_addr),
    .rom_icb_cmd_read  (cmd_read),
    .rom_icb_rsp_valid (rsp_valid),
    .rom_icb_rsp_ready (rsp_ready),
    .rom_icb_rsp_err   (rsp_err),
    .rom_icb_rsp_rdata (rsp_rdata),
`ifdef N101_MROM_ERR_CAPTURE_EN
    .rom_err_vld       (err_vld),
    .rom_err_addr      (err_addr),
    .rom_err_clr       (err_clr),
`endif
    .rom_idle          (idle)
  );

  // Expected ROM contents, hand-specified: word 2 is 0xDEADBEEF, others
  // 0xA5000000 ^ (index * 0x00010003).
  function automatic logic [31:0] exp_word(input int idx);
    logic [31:0] x;
    x = 32'(idx);
    if (idx == 2) return 32'hDEAD_BEEF;
    return 32'hA500_0000 ^ (x * 32'h0001_0003);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated command with rsp_ready=1: response after one edge, gone after the next.
  task automatic one_cmd(input string tag, input logic [AW-1:0] a, input logic rd,
                         input logic e_err, input logic [31:0] e_data);
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_err"}, 64'(rsp_err), 64'(e_err));
    chk({tag, "_dat"}, 64'(rsp_rdata), 64'(e_data));
    $display("[TB] %s addr=%0h read=%0b -> err=%0b rdata=%08h", tag, a, rd, rsp_err, rsp_rdata);
    tick();
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_read = 1'b1; rsp_ready = 1'b0;
`ifdef N101_MROM_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif
    tick(); tick();
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_idle",  64'(idle),      64'd1);
    chk("rst_err",   64'(rsp_err),   64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
`ifdef N101_MROM_ERR_CAPTURE_EN
    chk("rst_cap_vld",  64'(err_vld),  64'd0);
    chk("rst_cap_addr", 64'(err_addr), 64'd0);
`endif
    rst_n = 1'b1;

    // Single read, one-cycle latency.
    rsp_ready = 1'b1;
    chk("single_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_addr = 13'h008; cmd_read = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("single_vld",  64'(rsp_valid), 64'd1);
    chk("single_dat",  64'(rsp_rdata), 64'hDEAD_BEEF);
    chk("single_err",  64'(rsp_err),   64'd0);
    chk("single_busy", 64'(idle),      64'd0);
    $display("[TB] single addr=008 -> rdata=%08h err=%0b", rsp_rdata, rsp_err);
    tick();
    chk("single_done", 64'(rsp_valid), 64'd0);
    chk("single_idle", 64'(idle),      64'd1);

    // Streaming: one command and one response per cycle.
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_addr = AW'(i * 4);
      chk($sformatf("stream%0d_ready", i), 64'(cmd_ready), 64'd1);
      tick();
      chk($sformatf("stream%0d_vld", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("stream%0d_dat", i), 64'(rsp_rdata), 64'(exp_word(i)));
      $display("[TB] stream addr=%03h -> rdata=%08h", i * 4, rsp_rdata);
    end
    cmd_valid = 1'b0;
    tick();
    chk("stream_end", 64'(rsp_valid), 64'd0);

    // Backpressure: FIFO fills at two, third command stalls, head stays stable.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 13'h000; tick();
    cmd_addr = 13'h004; tick();
    cmd_addr = 13'h008;
    chk("bp_stall", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold%0d_vld", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_hold%0d_dat", i), 64'(rsp_rdata), 64'(exp_word(0)));
      chk($sformatf("bp_hold%0d_rdy", i), 64'(cmd_ready), 64'd0);
      $display("[TB] backpressure hold %0d rdata=%08h ready=%0b", i, rsp_rdata, cmd_ready);
    end
    rsp_ready = 1'b1;
    chk("bp_nobypass", 64'(cmd_ready), 64'd0);
    tick();
    chk("bp_resp1", 64'(rsp_rdata), 64'(exp_word(1)));
    chk("bp_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    chk("bp_resp2", 64'(rsp_rdata), 64'(exp_word(2)));
    $display("[TB] backpressure released, third rdata=%08h", rsp_rdata);
    tick();
    chk("bp_idle", 64'(idle), 64'd1);

    // Error cases, each followed by a clean read.
    one_cmd("err_write",   13'h010, 1'b0, 1'b1, 32'h0);
    one_cmd("ok_after_wr", 13'h014, 1'b1, 1'b0, exp_word(5));
    one_cmd("err_misal",   13'h002, 1'b1, 1'b1, 32'h0);
    one_cmd("ok_after_ma", 13'h00C, 1'b1, 1'b0, exp_word(3));
    one_cmd("err_range",   13'h1000, 1'b1, 1'b1, 32'h0);
    one_cmd("ok_last",     13'h0FFC, 1'b1, 1'b0, exp_word(1023));
    one_cmd("err_top",     13'h1FFC, 1'b1, 1'b1, 32'h0);

    // Reset with two responses outstanding.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 13'h004; tick();
    cmd_addr = 13'h008; tick();
    cmd_valid = 1'b0;
    chk("mid_pending", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_vld",  64'(rsp_valid), 64'd0);
    chk("mid_rst_rdy",  64'(cmd_ready), 64'd1);
    chk("mid_rst_idle", 64'(idle),      64'd1);
    $display("[TB] mid-op reset: valid=%0b ready=%0b idle=%0b", rsp_valid, cmd_ready, idle);
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ghost%0d", i), 64'(rsp_valid), 64'd0);
    end

`ifdef N101_MROM_ERR_CAPTURE_EN
    // First-error capture is sticky; clear beats a simultaneous new error.
    one_cmd("cap_err1", 13'h040, 1'b0, 1'b1, 32'h0);
    one_cmd("cap_err2", 13'h080, 1'b0, 1'b1, 32'h0);
    chk("cap_vld",  64'(err_vld),  64'd1);
    chk("cap_addr", 64'(err_addr), 64'h040);
    $display("[TB] capture vld=%0b addr=%03h", err_vld, err_addr);
    err_clr = 1'b1; cmd_valid = 1'b1; cmd_addr = 13'h100; cmd_read = 1'b0;
    tick();
    err_clr = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b1;
    chk("cap_clr_wins", 64'(err_vld), 64'd0);
    $display("[TB] capture after clear+error vld=%0b", err_vld);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
